// File: rtl/frame_sequencer_if.sv
// Frame sequencer bus: frame control and pixel stream in, depth-stage writes out.
// The master drives pixels and frame control. The slave (the sequencer) drives status and writes.
interface frame_sequencer_if #(
  parameter int FB_BIT_WIDTH    = 16,
  parameter int DEPTH_BIT_WIDTH = 16,
  parameter int FB_ADDR_WIDTH   = 17
);
  logic                       frame_start_in;
  logic                       raster_done_in;
  logic                       pixel_valid_in;
  logic [FB_ADDR_WIDTH-1:0]   pixel_addr_in;
  logic [FB_BIT_WIDTH-1:0]    pixel_color_in;
  logic [DEPTH_BIT_WIDTH-1:0] pixel_depth_in;

  logic                       pixel_ready_out;
  logic                       busy_out;
  logic                       frame_done_out;
  logic                       drawing_out;
  logic                       fb_we_out;
  logic                       dp_we_out;
  logic                       dp_re_out;
  logic                       fb_front_out;
  logic [FB_ADDR_WIDTH-1:0]   fb_write_out;
  logic [FB_ADDR_WIDTH-1:0]   dp_write_out;
  logic [FB_BIT_WIDTH-1:0]    fb_value_out;
  logic [DEPTH_BIT_WIDTH-1:0] dp_value_out;

  modport master (
    output frame_start_in, raster_done_in, pixel_valid_in,
           pixel_addr_in, pixel_color_in, pixel_depth_in,
    input  pixel_ready_out, busy_out, frame_done_out, drawing_out,
           fb_we_out, dp_we_out, dp_re_out, fb_front_out,
           fb_write_out, dp_write_out, fb_value_out, dp_value_out
  );

  modport slave (
    input  frame_start_in, raster_done_in, pixel_valid_in,
           pixel_addr_in, pixel_color_in, pixel_depth_in,
    output pixel_ready_out, busy_out, frame_done_out, drawing_out,
           fb_we_out, dp_we_out, dp_re_out, fb_front_out,
           fb_write_out, dp_write_out, fb_value_out, dp_value_out
  );
endinterface

// File: rtl/frame_sequencer.sv
// Per-frame sequencer: clear all of the framebuffer and depth buffer, forward pixels, drain, then swap buffers.
// Pixel writes appear one cycle after they are sampled. Pixels are taken only in DRAW (pixel_ready_out) and are never buffered.
module frame_sequencer #(
  parameter int                         FB_BIT_WIDTH    = 16,
  parameter int                         DEPTH_BIT_WIDTH = 16,
  parameter int                         FB_ADDR_WIDTH   = 17,
  parameter int                         FB_SIZE         = 57600,
  parameter logic [FB_BIT_WIDTH-1:0]    CLEAR_COLOR     = '0,
  parameter logic [DEPTH_BIT_WIDTH-1:0] CLEAR_DEPTH     = '1,
  parameter int                         DRAIN_CYCLES    = 6
) (
  input logic              clk_in,
  input logic              rst_in,
  frame_sequencer_if.slave bus
);

  localparam int CW = $clog2(FB_SIZE + 1);
  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0]            CLR_LAST   = CW'(FB_SIZE - 1);
  localparam logic [FB_ADDR_WIDTH:0]   ADDR_LIMIT = (FB_ADDR_WIDTH + 1)'(FB_SIZE);
  localparam logic [DW-1:0]            DRAIN_LOAD = DW'(DRAIN_CYCLES);

  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, DRAIN, SWAP} state_t;

  state_t                     state, state_nxt;
  logic [CW-1:0]              clr_cnt, clr_cnt_nxt;
  logic [DW-1:0]              drn_cnt, drn_cnt_nxt;
  logic                       drawing_q, drawing_nxt;
  logic                       fb_we_q, fb_we_nxt;
  logic                       dp_we_q, dp_we_nxt;
  logic                       dp_re_q, dp_re_nxt;
  logic                       front_q, front_nxt;
  logic                       done_q, done_nxt;
  logic [FB_ADDR_WIDTH-1:0]   addr_q, addr_nxt;
  logic [FB_BIT_WIDTH-1:0]    color_q, color_nxt;
  logic [DEPTH_BIT_WIDTH-1:0] depth_q, depth_nxt;
  logic                       pix_ok;

  // Out-of-range pixels are dropped silently rather than aliased onto valid addresses.
  assign pix_ok = bus.pixel_valid_in && ({1'b0, bus.pixel_addr_in} < ADDR_LIMIT);

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    drn_cnt_nxt = drn_cnt;
    drawing_nxt = 1'b0;
    fb_we_nxt   = 1'b0;
    dp_we_nxt   = 1'b0;
    dp_re_nxt   = 1'b0;
    front_nxt   = front_q;
    done_nxt    = 1'b0;
    addr_nxt    = addr_q;
    color_nxt   = color_q;
    depth_nxt   = depth_q;
    case (state)
      IDLE: begin
        if (bus.frame_start_in) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      CLEAR: begin
        fb_we_nxt   = 1'b1;
        dp_we_nxt   = 1'b1;
        addr_nxt    = FB_ADDR_WIDTH'(clr_cnt);
        color_nxt   = CLEAR_COLOR;
        depth_nxt   = CLEAR_DEPTH;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == CLR_LAST) state_nxt = DRAW;
      end
      DRAW: begin
        if (pix_ok) begin
          drawing_nxt = 1'b1;
          fb_we_nxt   = 1'b1;
          dp_we_nxt   = 1'b1;
          dp_re_nxt   = 1'b1;
          addr_nxt    = bus.pixel_addr_in;
          color_nxt   = bus.pixel_color_in;
          depth_nxt   = bus.pixel_depth_in;
        end
        if (bus.raster_done_in) begin
          state_nxt   = DRAIN;
          drn_cnt_nxt = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        drn_cnt_nxt = drn_cnt - 1'b1;
        if (drn_cnt <= DW'(1)) state_nxt = SWAP;
      end
      SWAP: begin
        front_nxt = ~front_q;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      clr_cnt   <= '0;
      drn_cnt   <= '0;
      drawing_q <= 1'b0;
      fb_we_q   <= 1'b0;
      dp_we_q   <= 1'b0;
      dp_re_q   <= 1'b0;
      front_q   <= 1'b0;
      done_q    <= 1'b0;
      addr_q    <= '0;
      color_q   <= '0;
      depth_q   <= '0;
    end else begin
      state     <= state_nxt;
      clr_cnt   <= clr_cnt_nxt;
      drn_cnt   <= drn_cnt_nxt;
      drawing_q <= drawing_nxt;
      fb_we_q   <= fb_we_nxt;
      dp_we_q   <= dp_we_nxt;
      dp_re_q   <= dp_re_nxt;
      front_q   <= front_nxt;
      done_q    <= done_nxt;
      addr_q    <= addr_nxt;
      color_q   <= color_nxt;
      depth_q   <= depth_nxt;
    end
  end

  assign bus.pixel_ready_out = (state == DRAW);
  assign bus.busy_out        = (state != IDLE);
  assign bus.frame_done_out  = done_q;
  assign bus.drawing_out     = drawing_q;
  assign bus.fb_we_out       = fb_we_q;
  assign bus.dp_we_out       = dp_we_q;
  assign bus.dp_re_out       = dp_re_q;
  assign bus.fb_front_out    = front_q;
  assign bus.fb_write_out    = addr_q;
  assign bus.dp_write_out    = addr_q;
  assign bus.fb_value_out    = color_q;
  assign bus.dp_value_out    = depth_q;

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL have parameter FB_BIT_WIDTH, default 16: colour word width.
REQ-002 SHALL have parameter DEPTH_BIT_WIDTH, default 16: depth word width.
REQ-003 SHALL have parameter FB_ADDR_WIDTH, default 17: framebuffer/depth address width.
REQ-004 SHALL have parameter FB_SIZE, default 57600: number of pixel addresses.
REQ-005 SHALL have parameter CLEAR_COLOR, default 0: clear colour value.
REQ-006 SHALL have parameter CLEAR_DEPTH, default all ones: clear depth value (farthest).
REQ-007 SHALL have parameter DRAIN_CYCLES, default 6: downstream pipeline drain count.
REQ-008 SHALL have one clock; reset is asynchronous and active-high (ports clk_in, rst_in).
REQ-009 SHALL have these ports: clk_in in 1 clock; rst_in in 1 async active-high reset.
REQ-010 SHALL have these ports: frame_start_in in 1 frame request pulse; raster_done_in in 1 last-pixel marker.
REQ-011 SHALL have these pixel input ports: pixel_valid_in in 1; pixel_addr_in in FB_ADDR_WIDTH; pixel_color_in in FB_BIT_WIDTH; pixel_depth_in in DEPTH_BIT_WIDTH.
REQ-012 SHALL have these status outputs: pixel_ready_out out 1 accept; busy_out out 1; frame_done_out out 1 pulse.
REQ-013 SHALL have these depth-stage control outputs: drawing_out, fb_we_out, dp_we_out, dp_re_out, fb_front_out, each out 1.
REQ-014 SHALL have these depth-stage data outputs: fb_write_out and dp_write_out out FB_ADDR_WIDTH; fb_value_out out FB_BIT_WIDTH; dp_value_out out DEPTH_BIT_WIDTH.

Function
REQ-015 SHALL implement states IDLE, CLEAR, DRAW, DRAIN, SWAP; all outputs registered except pixel_ready_out = (state==DRAW), busy_out = (state!=IDLE).
REQ-016 SHALL, in IDLE, drive fb_we_out=dp_we_out=dp_re_out=drawing_out=0; frame_start_in high -> CLEAR with counter 0; frame_start_in in any other state ignored.
REQ-017 SHALL, in CLEAR, at each edge: fb_we_out=dp_we_out=1, drawing_out=0, dp_re_out=0, fb_write_out=dp_write_out=counter, fb_value_out=CLEAR_COLOR, dp_value_out=CLEAR_DEPTH, counter+1.
REQ-018 SHALL emit exactly FB_SIZE consecutive clear writes, addresses 0..FB_SIZE-1 ascending, no gaps; the edge issuing address FB_SIZE-1 moves to DRAW.
REQ-019 SHALL ignore pixel_valid_in outside DRAW (pixels are not buffered).
REQ-020 SHALL, in DRAW, on an edge with pixel_valid_in=1, output drawing_out=fb_we_out=dp_we_out=dp_re_out=1, fb_write_out=dp_write_out=pixel_addr_in, fb_value_out=pixel_color_in, dp_value_out=pixel_depth_in (1-cycle latency).
REQ-021 SHALL, in DRAW, drive all write/read enables 0 on an edge with pixel_valid_in=0; data outputs hold.
REQ-022 SHALL drop any pixel with pixel_addr_in >= FB_SIZE: enables 0, no other effect.
REQ-023 SHALL, on raster_done_in in DRAW, still accept a simultaneous valid pixel, then enter DRAIN with drain counter = DRAIN_CYCLES.
REQ-024 SHALL, in DRAIN, drive all enables 0 and decrement each cycle; DRAIN lasts exactly DRAIN_CYCLES cycles, then SWAP.
REQ-025 SHALL, in SWAP (one cycle), toggle fb_front_out, pulse frame_done_out for exactly one cycle, return to IDLE.
REQ-026 SHALL hold fb_front_out constant for all writes within one frame.
REQ-027 SHALL use counter width ceil(log2(FB_SIZE+1)); no wrap occurs.

Reset
REQ-028 SHALL, on rst_in high at any time, asynchronously force state IDLE, counters 0, all 1-bit outputs 0, all address/value outputs 0.
REQ-029 SHALL, when reset asserts mid-CLEAR or mid-DRAW, not resume; a new frame_start_in restarts the clear at address 0.

Verification (FB_SIZE=16, DRAIN_CYCLES=6)
REQ-030 SHALL verify: frame_start_in pulse in IDLE -> 16 consecutive cycles fb_we_out=dp_we_out=1, addresses 0..15, dp_value_out=16'hFFFF, drawing_out=0; then pixel_ready_out=1.
REQ-031 SHALL verify: in DRAW, pixel valid addr=5 color=16'h1234 depth=16'h0100 -> next edge drawing_out=1, fb_write_out=5, fb_value_out=16'h1234, dp_value_out=16'h0100, dp_re_out=1.
REQ-032 SHALL verify: pixel addr=16 in DRAW -> all enables 0; pixel valid during CLEAR -> no pixel write appears.
REQ-033 SHALL verify: raster_done_in with valid pixel addr=3 -> pixel written; 6 idle cycles; then fb_front_out 0->1 and one-cycle frame_done_out; second frame toggles 1->0.
REQ-034 SHALL verify: rst_in asserted at clear address 7 -> outputs 0 immediately without clock edge; next frame_start_in clears from address 0.
